// File: rtl/gcd_mmap_pkg.sv
// Shared register map, bus strobe encodings and sequencer states for the GCD bus master.
package gcd_mmap_pkg;

  localparam logic [31:0] GCD_OFS_STATUS = 32'h0000_0000;
  localparam logic [31:0] GCD_OFS_Y      = 32'h0000_0004;
  localparam logic [31:0] GCD_OFS_A      = 32'h0000_0008;
  localparam logic [31:0] GCD_OFS_B      = 32'h0000_000C;
  localparam logic [31:0] GCD_OFS_START  = 32'h0000_0010;

  localparam logic [3:0] WSTRB_WR = 4'hF;
  localparam logic [3:0] WSTRB_RD = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_A     = 3'd1,
    ST_WR_B     = 3'd2,
    ST_WR_START = 3'd3,
    ST_POLL     = 3'd4,
    ST_RD_Y     = 3'd5,
    ST_RESP     = 3'd6
  } state_t;

  function automatic logic is_bus_state(input state_t s);
    return (s == ST_WR_A) || (s == ST_WR_B) || (s == ST_WR_START) ||
           (s == ST_POLL) || (s == ST_RD_Y);
  endfunction

endpackage

// File: rtl/gcd_mmap_master_xact.sv
// Single native-bus transaction engine: registers the request, holds it until
// mem_ready or timeout, and reports completion in the following (idle) cycle.
module mmap_xact
  import gcd_mmap_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        is_wr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata_q
);

  logic [15:0] cnt;

  // done/err are high in the cycle after the bus edge, which is also the
  // mandatory idle gap; a go seen then launches the next request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata_q   <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (mem_valid) begin
        if (mem_ready) begin
          mem_valid <= 1'b0;
          done      <= 1'b1;
          rdata_q   <= mem_rdata;
        end else if (cnt == TIMEOUT - 16'd1) begin
          mem_valid <= 1'b0;
          err       <= 1'b1;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else if (go) begin
        mem_valid <= 1'b1;
        mem_addr  <= addr;
        mem_wstrb <= is_wr ? WSTRB_WR : WSTRB_RD;
        mem_wdata <= is_wr ? wdata : 32'h0;
        cnt       <= '0;
      end
    end
  end

endmodule

// File: rtl/gcd_mmap_master.sv
// Command-driven bus master for the GCD peripheral: writes A, B, START, polls
// STATUS until idle, reads Y and returns it (or an error) on a response handshake.
module gcd_mmap_master
  import gcd_mmap_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter logic [15:0] TIMEOUT    = 16'd1024,
  parameter logic [15:0] POLL_LIMIT = 16'd4096,
  parameter logic [31:0] BUSY_MASK  = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_y,
  output logic        rsp_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  state_t      state, nxt;
  logic        launch_q;
  logic [31:0] a_q, b_q;
  logic [15:0] poll_cnt;
  logic        x_go, x_wr, x_done, x_err;
  logic [31:0] x_addr, x_wdata, x_rdata;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  // Next state is resolved during the gap cycle so the following request
  // can be launched on the same edge, keeping 3 cycles per transaction.
  always_comb begin
    nxt = state;
    if (x_err) begin
      nxt = ST_RESP;
    end else if (x_done) begin
      case (state)
        ST_WR_A:     nxt = ST_WR_B;
        ST_WR_B:     nxt = ST_WR_START;
        ST_WR_START: nxt = ST_POLL;
        ST_POLL: begin
          if ((x_rdata & BUSY_MASK) == 32'h0)    nxt = ST_RD_Y;
          else if (poll_cnt == POLL_LIMIT - 16'd1) nxt = ST_RESP;
          else                                    nxt = ST_POLL;
        end
        ST_RD_Y:     nxt = ST_RESP;
        default:     nxt = state;
      endcase
    end
  end

  always_comb begin
    x_go    = (launch_q || x_done) && is_bus_state(nxt);
    x_addr  = BASE_ADDR + GCD_OFS_STATUS;
    x_wdata = 32'h0;
    x_wr    = 1'b0;
    case (nxt)
      ST_WR_A:     begin x_addr = BASE_ADDR + GCD_OFS_A;     x_wdata = a_q;   x_wr = 1'b1; end
      ST_WR_B:     begin x_addr = BASE_ADDR + GCD_OFS_B;     x_wdata = b_q;   x_wr = 1'b1; end
      ST_WR_START: begin x_addr = BASE_ADDR + GCD_OFS_START; x_wdata = 32'h1; x_wr = 1'b1; end
      ST_RD_Y:     x_addr = BASE_ADDR + GCD_OFS_Y;
      default:     x_addr = BASE_ADDR + GCD_OFS_STATUS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      launch_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      poll_cnt <= '0;
      rsp_y    <= '0;
      rsp_err  <= 1'b0;
    end else begin
      launch_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            a_q      <= cmd_a;
            b_q      <= cmd_b;
            poll_cnt <= '0;
            rsp_y    <= '0;
            rsp_err  <= 1'b0;
            state    <= ST_WR_A;
            launch_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: begin
          if (x_err) begin
            state   <= ST_RESP;
            rsp_err <= 1'b1;
            rsp_y   <= '0;
          end else if (x_done) begin
            state <= nxt;
            if (state == ST_POLL && nxt == ST_POLL) poll_cnt <= poll_cnt + 16'd1;
            if (state == ST_POLL && nxt == ST_RESP) begin
              rsp_err <= 1'b1;
              rsp_y   <= '0;
            end
            if (state == ST_RD_Y) rsp_y <= x_rdata;
          end
        end
      endcase
    end
  end

  mmap_xact #(
    .TIMEOUT(TIMEOUT)
  ) u_xact (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (x_go),
    .addr      (x_addr),
    .wdata     (x_wdata),
    .is_wr     (x_wr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .done      (x_done),
    .err       (x_err),
    .rdata_q   (x_rdata)
  );

endmodule

// File: tb/tb_gcd_mmap_master.sv
// Directed bench for gcd_mmap_master with a behavioural GCD peripheral on the native bus.
module tb_gcd_mmap_master;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] cmd_a, cmd_b, rsp_y;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  gcd_mmap_master #(
    .BASE_ADDR (BASE),
    .TIMEOUT   (16'd16),
    .POLL_LIMIT(16'd8),
    .BUSY_MASK (32'h0000_0001)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Slave configuration (written only by the stimulus block)
  int          delay, busy_reads;
  logic [31:0] stall_addr, y_val;
  logic        clr;

  // Slave observations (written only by the slave block)
  int          wcnt, st_reads, y_reads, vcyc, stall_cyc, unstable, gap_viol, bad_bus;
  logic [31:0] wr_a, wr_b, wr_st;
  logic        prev_valid, prev_done;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_wstrb;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
      wcnt      <= 0;
    end else begin
      mem_ready <= 1'b0;
      if (!mem_valid) wcnt <= 0;
      if (mem_valid) begin
        vcyc <= vcyc + 1;
        if (mem_addr == stall_addr) stall_cyc <= stall_cyc + 1;
      end
      if (mem_valid && prev_valid && !prev_done &&
          (mem_addr != prev_addr || mem_wdata != prev_wdata || mem_wstrb != prev_wstrb))
        unstable <= unstable + 1;
      if (mem_valid && prev_done) gap_viol <= gap_viol + 1;
      if (mem_valid && !mem_ready) begin
        if (wcnt >= delay && mem_addr != stall_addr) begin
          mem_ready <= 1'b1;
          wcnt      <= 0;
          case (mem_addr)
            BASE + 32'h08: begin wr_a  <= mem_wdata; if (mem_wstrb != 4'hF) bad_bus <= bad_bus + 1; end
            BASE + 32'h0C: begin wr_b  <= mem_wdata; if (mem_wstrb != 4'hF) bad_bus <= bad_bus + 1; end
            BASE + 32'h10: begin wr_st <= mem_wdata; if (mem_wstrb != 4'hF) bad_bus <= bad_bus + 1; end
            BASE + 32'h00: begin
              mem_rdata <= (st_reads < busy_reads) ? 32'h1 : 32'h0;
              st_reads  <= st_reads + 1;
              if (mem_wstrb != 4'h0 || mem_wdata != 32'h0) bad_bus <= bad_bus + 1;
            end
            BASE + 32'h04: begin
              mem_rdata <= y_val;
              y_reads   <= y_reads + 1;
              if (mem_wstrb != 4'h0 || mem_wdata != 32'h0) bad_bus <= bad_bus + 1;
            end
            default: bad_bus <= bad_bus + 1;
          endcase
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
    prev_valid <= mem_valid;
    prev_done  <= mem_valid && mem_ready;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
    prev_wstrb <= mem_wstrb;
    if (clr) begin
      st_reads <= 0; y_reads <= 0; vcyc <= 0; stall_cyc <= 0;
      unstable <= 0; gap_viol <= 0; bad_bus <= 0;
      wr_a <= 32'h0; wr_b <= 32'h0; wr_st <= 32'h0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic setup(input int d, input int br, input logic [31:0] sa, input logic [31:0] y);
    delay = d; busy_reads = br; stall_addr = sa; y_val = y;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic do_cmd(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(rsp_valid), 32'd1);
  endtask

  task automatic take_rsp(input string tag);
    chk({tag, "_cmd_ready_pre"}, 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_cmd_ready_post"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_rsp_valid_post"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic hold_ok;
    logic found;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    clr = 1'b0; delay = 0; busy_reads = 0; stall_addr = 32'h0; y_val = 32'h0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_y",     rsp_y,          32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr",  mem_addr,       32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 48/18, zero-wait slave, busy for 3 STATUS reads; then response held back
    setup(0, 3, 32'h0, 32'd6);
    do_cmd(32'd48, 32'd18);
    wait_rsp("t1_rsp");
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = (i == 3);
      cmd_a = 32'd5; cmd_b = 32'd5;
      @(negedge clk);
      if (!(rsp_valid && rsp_y == 32'd6 && !rsp_err && !cmd_ready && !mem_valid)) hold_ok = 1'b0;
    end
    cmd_valid = 1'b0;
    chk("t5_hold_stable", 32'(hold_ok), 32'd1);
    chk("t1_wr_a",     wr_a,            32'd48);
    chk("t1_wr_b",     wr_b,            32'd18);
    chk("t1_wr_start", wr_st,           32'd1);
    chk("t1_status",   32'(st_reads),   32'd4);
    chk("t1_y_reads",  32'(y_reads),    32'd1);
    chk("t1_valid_cyc",32'(vcyc),       32'd16);
    chk("t1_gap",      32'(gap_viol),   32'd0);
    chk("t1_bus_fmt",  32'(bad_bus),    32'd0);
    chk("t1_rsp_y",    rsp_y,           32'd6);
    chk("t1_rsp_err",  32'(rsp_err),    32'd0);
    take_rsp("t5");
    @(negedge clk);
    chk("t5_no_extra_cmd", 32'(mem_valid | busy), 32'd0);

    // Slave never answers the B write
    setup(0, 0, BASE + 32'h0C, 32'd9);
    do_cmd(32'd10, 32'd4);
    wait_rsp("t2_rsp");
    chk("t2_stall_cyc", 32'(stall_cyc), 32'd16);
    chk("t2_rsp_err",   32'(rsp_err),   32'd1);
    chk("t2_rsp_y",     rsp_y,          32'd0);
    chk("t2_mem_valid", 32'(mem_valid), 32'd0);
    chk("t2_no_start",  wr_st,          32'd0);
    take_rsp("t2");

    // STATUS always busy
    setup(0, 100000, 32'h0, 32'd9);
    do_cmd(32'd12, 32'd8);
    wait_rsp("t3_rsp");
    chk("t3_status", 32'(st_reads), 32'd8);
    chk("t3_y_reads",32'(y_reads),  32'd0);
    chk("t3_rsp_err",32'(rsp_err),  32'd1);
    chk("t3_rsp_y",  rsp_y,         32'd0);
    take_rsp("t3");

    // Five-cycle ready delay on every access
    setup(5, 2, 32'h0, 32'd6);
    do_cmd(32'd270, 32'd192);
    wait_rsp("t4_rsp");
    chk("t4_stable",  32'(unstable), 32'd0);
    chk("t4_wr_a",    wr_a,          32'd270);
    chk("t4_wr_b",    wr_b,          32'd192);
    chk("t4_status",  32'(st_reads), 32'd3);
    chk("t4_rsp_y",   rsp_y,         32'd6);
    chk("t4_rsp_err", 32'(rsp_err),  32'd0);
    take_rsp("t4");

    // Reset while a STATUS read is on the bus
    setup(3, 100000, 32'h0, 32'd9);
    do_cmd(32'd100, 32'd75);
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge clk);
      if (st_reads >= 2 && mem_valid && mem_addr == BASE) found = 1'b1;
    end
    chk("t6_reach_poll", 32'(found), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_mem_valid", 32'(mem_valid), 32'd0);
    chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t6_busy",      32'(busy),      32'd0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_mem_addr",  mem_addr,       32'd0);
    rst_n = 1'b1;
    setup(0, 1, 32'h0, 32'd7);
    chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    do_cmd(32'd35, 32'd14);
    wait_rsp("t6_rsp");
    chk("t6_wr_a",    wr_a,         32'd35);
    chk("t6_wr_b",    wr_b,         32'd14);
    chk("t6_rsp_y",   rsp_y,        32'd7);
    chk("t6_rsp_err", 32'(rsp_err), 32'd0);
    take_rsp("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
